tty_sequencer: RTL and testbench

TTY_SEQUENCER -- requirements
Module: tty_sequencer

---
 rtl/tty_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_tty_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_sequencer.sv
// Teletype register-port sequencer: feeds the keyboard register from a host FIFO and drains
// the printer register into a host FIFO, pacing each printed character by CHARCLKS cycles.
module tty_sequencer #(
  parameter int unsigned KBDEPTH  = 16,
  parameter int unsigned PRDEPTH  = 16,
  parameter int unsigned CHARCLKS = 100000
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       kb_valid,
  input  logic [7:0]                 kb_data,
  output logic                       kb_ready,
  output logic                       pr_valid,
  output logic [7:0]                 pr_data,
  input  logic                       pr_ready,
  output logic [$clog2(KBDEPTH):0]   kb_count,
  output logic [$clog2(PRDEPTH):0]   pr_count,
  output logic                       tty_armwrite,
  output logic [1:0]                 tty_armwaddr,
  output logic [1:0]                 tty_armraddr,
  output logic [31:0]                tty_armwdata,
  input  logic [31:0]                tty_armrdata
);

  localparam int unsigned KA = $clog2(KBDEPTH);
  localparam int unsigned KW = KA + 1;
  localparam int unsigned PA = $clog2(PRDEPTH);
  localparam int unsigned PW = PA + 1;
  localparam int unsigned TW = (CHARCLKS > 1) ? $clog2(CHARCLKS) : 1;
  localparam logic [KW-1:0] KbFull = KW'(KBDEPTH);
  localparam logic [PW-1:0] PrFull = PW'(PRDEPTH);
  localparam logic [TW-1:0] TLoad  = TW'(CHARCLKS - 1);

  typedef enum logic [2:0] {StKbRd, StKbChk, StKbWr, StPrRd, StPrChk, StPrWr} state_e;

  state_e          state_q;
  logic            busy_q;
  logic [TW-1:0]   timer_q;
  logic            kb_en_q;
  logic            run_q;

  logic [7:0]      kb_mem [KBDEPTH];
  logic [KA-1:0]   kb_wp_q, kb_rp_q;
  logic [KW-1:0]   kb_cnt_q;
  logic [7:0]      pr_mem [PRDEPTH];
  logic [PA-1:0]   pr_wp_q, pr_rp_q;
  logic [PW-1:0]   pr_cnt_q;

  logic kb_push, kb_pop, pr_push, pr_pop, pr_take;
  logic unused_rdata;

  assign unused_rdata = ^tty_armrdata[29:8];

  assign kb_ready = (kb_cnt_q != KbFull);
  assign kb_count = kb_cnt_q;
  assign pr_valid = (pr_cnt_q != '0);
  assign pr_data  = pr_mem[pr_rp_q];
  assign pr_count = pr_cnt_q;

  assign kb_push = kb_valid && kb_ready && !flush;
  assign kb_pop  = (state_q == StKbWr) && (kb_cnt_q != '0) && !flush;
  assign pr_pop  = pr_valid && pr_ready && !flush;
  // Teletype has a char and we are idle with room for it; otherwise leave it in place.
  assign pr_take = (state_q == StPrChk) && !busy_q && tty_armrdata[30] && (pr_cnt_q != PrFull);
  assign pr_push = pr_take && !flush;

  always_ff @(posedge CLOCK) begin
    if (kb_push) kb_mem[kb_wp_q] <= kb_data;
    if (pr_push) pr_mem[pr_wp_q] <= tty_armrdata[7:0];
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      kb_wp_q  <= '0;
      kb_rp_q  <= '0;
      kb_cnt_q <= '0;
    end else if (flush) begin
      kb_wp_q  <= '0;
      kb_rp_q  <= '0;
      kb_cnt_q <= '0;
    end else begin
      if (kb_push) kb_wp_q <= kb_wp_q + KA'(1);
      if (kb_pop)  kb_rp_q <= kb_rp_q + KA'(1);
      if (kb_push && !kb_pop)      kb_cnt_q <= kb_cnt_q + KW'(1);
      else if (kb_pop && !kb_push) kb_cnt_q <= kb_cnt_q - KW'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pr_wp_q  <= '0;
      pr_rp_q  <= '0;
      pr_cnt_q <= '0;
    end else if (flush) begin
      pr_wp_q  <= '0;
      pr_rp_q  <= '0;
      pr_cnt_q <= '0;
    end else begin
      if (pr_push) pr_wp_q <= pr_wp_q + PA'(1);
      if (pr_pop)  pr_rp_q <= pr_rp_q + PA'(1);
      if (pr_push && !pr_pop)      pr_cnt_q <= pr_cnt_q + PW'(1);
      else if (pr_pop && !pr_push) pr_cnt_q <= pr_cnt_q - PW'(1);
    end
  end

  // run_q delays the first KBCHK by one cycle after reset release.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StKbRd;
      busy_q  <= 1'b0;
      timer_q <= '0;
      kb_en_q <= 1'b0;
      run_q   <= 1'b0;
    end else if (flush) begin
      state_q <= StKbRd;
      busy_q  <= 1'b0;
      timer_q <= '0;
      run_q   <= 1'b1;
    end else begin
      run_q <= 1'b1;
      if (busy_q && (timer_q != '0)) timer_q <= timer_q - TW'(1);
      case (state_q)
        StKbRd: if (enable && run_q) state_q <= StKbChk;
        StKbChk: begin
          if (!tty_armrdata[31] && (kb_cnt_q != '0)) begin
            state_q <= StKbWr;
            kb_en_q <= tty_armrdata[30];
          end else begin
            state_q <= StPrRd;
          end
        end
        StKbWr: state_q <= StPrRd;
        StPrRd: state_q <= StPrChk;
        StPrChk: begin
          if (busy_q && (timer_q == '0)) begin
            state_q <= StPrWr;
          end else begin
            if (pr_take) begin
              busy_q  <= 1'b1;
              timer_q <= TLoad;
            end
            state_q <= StKbRd;
          end
        end
        StPrWr: begin
          busy_q  <= 1'b0;
          state_q <= StKbRd;
        end
        default: state_q <= StKbRd;
      endcase
    end
  end

  // Write strobe decoded from state, suppressed by a same-cycle flush.
  always_comb begin
    tty_armwrite = 1'b0;
    tty_armwaddr = 2'd0;
    tty_armwdata = 32'd0;
    tty_armraddr = 2'd1;
    case (state_q)
      StPrRd, StPrChk, StPrWr: tty_armraddr = 2'd2;
      default:                 tty_armraddr = 2'd1;
    endcase
    if (!flush) begin
      case (state_q)
        StKbWr: begin
          tty_armwrite = 1'b1;
          tty_armwaddr = 2'd1;
          tty_armwdata = {1'b1, kb_en_q, 22'b0, kb_mem[kb_rp_q]};
        end
        StPrWr: begin
          tty_armwrite = 1'b1;
          tty_armwaddr = 2'd2;
          tty_armwdata = 32'h8000_0000;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tty_sequencer.sv
// Self-checking bench for tty_sequencer: teletype register model, queue scoreboard,
// table-driven keyboard vectors, directed corner cases and a randomized phase.
module tb_tty_sequencer;
  localparam int unsigned KBD = 16;
  localparam int unsigned PRD = 2;
  localparam int unsigned CC  = 8;

  logic        CLOCK = 1'b0;
  logic        RESET_N, enable, flush, kb_valid, kb_ready, pr_valid, pr_ready;
  logic [7:0]  kb_data, pr_data;
  logic [4:0]  kb_count;
  logic [1:0]  pr_count;
  logic        tty_armwrite;
  logic [1:0]  tty_armwaddr, tty_armraddr;
  logic [31:0] tty_armwdata, tty_armrdata;

  // Teletype register model: reg 1 = {kbflag, kben}, reg 2 = {0, prfull, ..., prchar}.
  logic       kbflag, kben, prfull;
  logic [7:0] prchar;
  assign tty_armrdata = (tty_armraddr == 2'd2) ? {1'b0, prfull, 22'b0, prchar}
                                               : {kbflag, kben, 30'b0};

  tty_sequencer #(.KBDEPTH(KBD), .PRDEPTH(PRD), .CHARCLKS(CC)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .enable(enable), .flush(flush),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .pr_valid(pr_valid), .pr_data(pr_data), .pr_ready(pr_ready),
    .kb_count(kb_count), .pr_count(pr_count),
    .tty_armwrite(tty_armwrite), .tty_armwaddr(tty_armwaddr), .tty_armraddr(tty_armraddr),
    .tty_armwdata(tty_armwdata), .tty_armrdata(tty_armrdata)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit mon_en = 0, auto_ack = 1, pending = 0;
  int offer_cyc = 0, kb_writes = 0, pr_writes = 0;
  logic [31:0] last_wdata = '0;
  logic [7:0] kbq[$];
  logic [7:0] prq[$];

  typedef struct { logic [7:0] ch; logic ben; logic [31:0] exp; } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample pre-edge at #1, score handshakes/writes, return at the next negedge.
  task automatic step();
    logic kr, kv, pv, prdy, w;
    logic [7:0] kd, pd, head;
    logic [1:0] wa;
    logic [31:0] wd;
    logic [4:0] kc;
    #1;
    kr = kb_ready; kv = kb_valid; kd = kb_data; pv = pr_valid; pd = pr_data; prdy = pr_ready;
    w = tty_armwrite; wa = tty_armwaddr; wd = tty_armwdata; kc = kb_count;
    if (mon_en) begin
      check("kb_count", 32'(kc), 32'(kbq.size()));
      check("kb_ready", 32'(kr), 32'(kbq.size() < KBD));
      if (!w) begin
        check("idle_waddr", 32'(wa), 32'd0);
        check("idle_wdata", wd, 32'd0);
      end else if (wa == 2'd1) begin
        kb_writes++;
        last_wdata = wd;
        check("kb_write_flag_clear", 32'(kbflag), 32'd0);
        check("kb_write_nonempty", 32'(kbq.size() != 0), 32'd1);
        if (kbq.size() != 0) begin
          head = kbq.pop_front();
          check("kb_wdata", wd, {1'b1, kben, 22'b0, head});
        end
        if (!auto_ack) kbflag = 1'b1;
      end else if (wa == 2'd2) begin
        pr_writes++;
        last_wdata = wd;
        check("pr_wdata", wd, 32'h8000_0000);
        check("pr_write_pending", 32'(pending), 32'd1);
        check("pr_char_time", 32'((cyc - offer_cyc) >= int'(CC)), 32'd1);
        pending = 0;
        prfull = 1'b0;
      end else begin
        check("waddr_legal", 32'(wa), 32'd1);
      end
      if (kv && kr) kbq.push_back(kd);
      if (pv && prdy) begin
        check("pr_pop_expected", 32'(prq.size() != 0), 32'd1);
        if (prq.size() != 0) begin
          head = prq.pop_front();
          check("pr_data", 32'(pd), 32'(head));
        end
      end
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
    cyc++;
  endtask

  task automatic offer(input logic [7:0] ch);
    prfull = 1'b1; prchar = ch; prq.push_back(ch); pending = 1; offer_cyc = cyc;
  endtask

  task automatic wait_kb_write(input int bound, input string name);
    int w0 = kb_writes;
    for (int k = 0; k < bound && kb_writes == w0; k++) step();
    check(name, 32'(kb_writes - w0), 32'd1);
  endtask

  task automatic wait_pr_write(input int bound, input string name);
    int w0 = pr_writes;
    for (int k = 0; k < bound && pr_writes == w0; k++) step();
    check(name, 32'(pr_writes - w0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, wc;
    bit found;
    vecs[0] = '{ch: 8'h41, ben: 1'b1, exp: 32'hC000_0041};
    vecs[1] = '{ch: 8'h00, ben: 1'b0, exp: 32'h8000_0000};
    vecs[2] = '{ch: 8'hFF, ben: 1'b1, exp: 32'hC000_00FF};
    vecs[3] = '{ch: 8'h7E, ben: 1'b0, exp: 32'h8000_007E};
    vecs[4] = '{ch: 8'hA5, ben: 1'b1, exp: 32'hC000_00A5};

    RESET_N = 0; enable = 0; flush = 0; kb_valid = 0; kb_data = 0; pr_ready = 0;
    kbflag = 0; kben = 1; prfull = 0; prchar = 0;
    repeat (2) @(negedge CLOCK);
    #1;
    check("rst_write", 32'(tty_armwrite), 32'd0);
    check("rst_waddr", 32'(tty_armwaddr), 32'd0);
    check("rst_wdata", tty_armwdata, 32'd0);
    check("rst_raddr", 32'(tty_armraddr), 32'd1);
    check("rst_kb_ready", 32'(kb_ready), 32'd1);
    check("rst_pr_valid", 32'(pr_valid), 32'd0);
    check("rst_kb_count", 32'(kb_count), 32'd0);
    check("rst_pr_count", 32'(pr_count), 32'd0);
    @(negedge CLOCK);
    enable = 1; RESET_N = 1; mon_en = 1; auto_ack = 1;

    // Table: single char into an empty FIFO, one write within 6 cycles.
    for (int i = 0; i < 5; i++) begin
      kben = vecs[i].ben;
      w0 = kb_writes;
      kb_valid = 1; kb_data = vecs[i].ch;
      step();
      kb_valid = 0;
      wait_kb_write(6, "kb_write_latency");
      check("kb_wdata_table", last_wdata, vecs[i].exp);
      repeat (6) step();
      check("kb_single_write", 32'(kb_writes - w0), 32'd1);
      check("kb_count_drained", 32'(kb_count), 32'd0);
    end
    kben = 1;

    // Stall while kbflag=1.
    kbflag = 1; w0 = kb_writes;
    kb_valid = 1; kb_data = 8'h42;
    step();
    kb_valid = 0;
    repeat (16) step();
    check("kb_stall_no_write", 32'(kb_writes - w0), 32'd0);
    check("kb_stall_count", 32'(kb_count), 32'd1);
    kbflag = 0;
    wait_kb_write(8, "kb_unstall_write");
    check("kb_unstall_wdata", last_wdata, 32'hC000_0042);

    // Fill keyboard FIFO with 17 chars while stalled.
    kbflag = 1; kb_valid = 1;
    for (int i = 0; i < 17; i++) begin
      kb_data = 8'(8'h60 + i);
      step();
    end
    kb_valid = 0;
    check("kb_full_count", 32'(kb_count), 32'd16);
    check("kb_full_ready", 32'(kb_ready), 32'd0);
    kbflag = 0;
    for (int k = 0; k < 200 && kb_count != 0; k++) step();
    check("kb_full_drain", 32'(kb_count), 32'd0);

    // Printer char 0x0D paced by CHARCLKS.
    pr_ready = 0;
    offer(8'h0D);
    for (int k = 0; k < 12 && !pr_valid; k++) step();
    check("pr_valid_0d", 32'(pr_valid), 32'd1);
    check("pr_data_0d", 32'(pr_data), 32'h0D);
    wait_pr_write(20, "prwr_0d");
    pr_ready = 1; step(); pr_ready = 0;
    check("pr_count_after_pop", 32'(pr_count), 32'd0);

    // Printer FIFO full back-pressure.
    offer(8'h11); wait_pr_write(24, "prwr_a");
    offer(8'h22); wait_pr_write(24, "prwr_b");
    check("pr_full_count", 32'(pr_count), 32'd2);
    offer(8'h33); w0 = pr_writes;
    repeat (20) step();
    check("pr_full_no_prwr", 32'(pr_writes - w0), 32'd0);
    check("pr_full_held", 32'(pr_count), 32'd2);
    pr_ready = 1; step(); pr_ready = 0;
    for (int k = 0; k < 6 && pr_count != 2'd2; k++) step();
    check("pr_retry_push", 32'(pr_count), 32'd2);
    wait_pr_write(24, "prwr_c");
    pr_ready = 1;
    for (int k = 0; k < 6 && pr_count != 0; k++) step();
    pr_ready = 0;
    check("pr_drain", 32'(pr_count), 32'd0);

    // Randomized traffic against the queue model.
    auto_ack = 0;
    for (int i = 0; i < 800; i++) begin
      kb_valid = ($urandom_range(0, 1) == 1);
      kb_data  = 8'($urandom);
      pr_ready = ($urandom_range(0, 3) != 0);
      if (kbflag && $urandom_range(0, 2) == 0) kbflag = 0;
      if (!prfull && $urandom_range(0, 5) == 0) offer(8'($urandom));
      step();
    end
    auto_ack = 1; kbflag = 0; kb_valid = 0; pr_ready = 1;
    for (int k = 0; k < 300 && !(kb_count == 0 && !prfull && pr_count == 0); k++) step();
    check("rand_drain_kb", 32'(kb_count), 32'd0);
    check("rand_drain_pr", 32'(pr_count), 32'd0);
    check("rand_drain_prq", 32'(prq.size()), 32'd0);
    check("rand_drain_prfull", 32'(prfull), 32'd0);
    pr_ready = 0;

    // Reset asserted mid-KBWR.
    mon_en = 0;
    kb_valid = 1; kb_data = 8'h55;
    @(posedge CLOCK); @(negedge CLOCK);
    kb_valid = 0; found = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (tty_armwrite) begin found = 1; break; end
      @(negedge CLOCK);
    end
    check("rst_kbwr_reached", 32'(found), 32'd1);
    RESET_N = 0;
    #1;
    check("rst_mid_write", 32'(tty_armwrite), 32'd0);
    check("rst_mid_waddr", 32'(tty_armwaddr), 32'd0);
    check("rst_mid_wdata", tty_armwdata, 32'd0);
    check("rst_mid_raddr", 32'(tty_armraddr), 32'd1);
    check("rst_mid_kb_count", 32'(kb_count), 32'd0);
    check("rst_mid_kb_ready", 32'(kb_ready), 32'd1);
    @(negedge CLOCK);
    RESET_N = 1;

    // Flush on the KBWR cycle suppresses the strobe.
    kb_valid = 1; kb_data = 8'h66;
    @(posedge CLOCK); @(negedge CLOCK);
    kb_valid = 0; found = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (tty_armwrite) begin found = 1; break; end
      @(negedge CLOCK);
    end
    check("flush_kbwr_reached", 32'(found), 32'd1);
    flush = 1;
    #1;
    check("flush_kbwr_write", 32'(tty_armwrite), 32'd0);
    check("flush_kbwr_wdata", tty_armwdata, 32'd0);
    @(negedge CLOCK);
    flush = 0;
    #1;
    check("flush_kb_count", 32'(kb_count), 32'd0);
    wc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK); #1;
      if (tty_armwrite) wc++;
    end
    check("flush_kb_no_write", 32'(wc), 32'd0);

    // Flush while the printer timer is running.
    prfull = 1; prchar = 8'h33; found = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK); #1;
      if (pr_valid) begin found = 1; break; end
    end
    check("flush_pr_pushed", 32'(found), 32'd1);
    @(negedge CLOCK); @(negedge CLOCK);
    flush = 1; prfull = 0;
    #1;
    check("flush_pr_write", 32'(tty_armwrite), 32'd0);
    @(negedge CLOCK);
    flush = 0;
    #1;
    check("flush_pr_count", 32'(pr_count), 32'd0);
    check("flush_pr_valid", 32'(pr_valid), 32'd0);
    wc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLOCK); #1;
      if (tty_armwrite) wc++;
    end
    check("flush_pr_no_prwr", 32'(wc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
